// File: rtl/icache_fetch_pkg.sv
// Shared types for the direct-mapped instruction cache: address slicing,
// frame layout and fetch FSM states for the default 16-set configuration.
package icache_fetch_pkg;

    localparam int unsigned ISETS  = 16;
    localparam int unsigned IIDX_W = $clog2(ISETS);
    localparam int unsigned ITAG_W = 30 - IIDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_fetch_if.sv
// Fetch-side and memory-side signals of the instruction cache; the cache
// modport is the cache's view, dp is the datapath/memory environment's view.
interface icache_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iinvalidate;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport cache (
        input  imemREN, imemaddr, iinvalidate, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport dp (
        output imemREN, imemaddr, iinvalidate, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_fetch_frame_array.sv
// Valid/tag/data storage for the instruction cache: one combinational read
// port, one write port, and a bulk invalidate that takes priority over writes.
module icache_frame_array #(
    parameter int unsigned SETS  = 16,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output logic [31:0]      rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  logic [31:0]      wdata,
    input  logic             inval
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags  [SETS];
    logic [31:0]      words [SETS];

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (inval) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= 1'b1;
        end
    end

    // Tag/data are left unreset; a set is only trusted once its valid bit is set.
    always_ff @(posedge CLK) begin
        if (we) begin
            tags[widx]  <= wtag;
            words[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tags[ridx];
    assign rdata  = words[ridx];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped one-word-per-set instruction cache with zero-cycle hits and
// a blocking single-request fill from the memory arbiter on a miss.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int unsigned SETS = 16
) (
    input  logic     CLK,
    input  logic     nRST,
    icache_if.cache  cif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    icache_state_t    state, next_state;
    logic [29:0]      miss_word;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             rvalid;
    logic [TAG_W-1:0] rtag;
    logic [31:0]      rdata;
    logic             hit;
    logic             miss_start;
    logic             fill_done;
    logic             unused_bytoff;

    assign req_idx       = cif.imemaddr[IDX_W+1:2];
    assign req_tag       = cif.imemaddr[31:IDX_W+2];
    assign unused_bytoff = ^cif.imemaddr[1:0];

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_frames (
        .CLK    (CLK),
        .nRST   (nRST),
        .ridx   (req_idx),
        .rvalid (rvalid),
        .rtag   (rtag),
        .rdata  (rdata),
        .we     (fill_done),
        .widx   (miss_word[IDX_W-1:0]),
        .wtag   (miss_word[29:IDX_W]),
        .wdata  (cif.iload),
        .inval  (cif.iinvalidate)
    );

    // A pending invalidate suppresses both hits and new misses in IDLE.
    assign hit        = (state == IDLE) && cif.imemREN && !cif.iinvalidate
                        && rvalid && (rtag == req_tag);
    assign miss_start = (state == IDLE) && cif.imemREN && !cif.iinvalidate && !hit;
    assign fill_done  = (state == FILL) && !cif.iwait;

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_word <= '0;
        end else begin
            state <= next_state;
            if (miss_start) begin
                miss_word <= cif.imemaddr[31:2];
            end
        end
    end

    // The fill always runs to completion; redirects and dropped requests are
    // looked up afresh once back in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (miss_start) next_state = FILL;
            FILL: if (fill_done)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cif.ihit     = 1'b0;
        cif.imemload = '0;
        cif.iREN     = 1'b0;
        cif.iaddr    = '0;
        if (hit) begin
            cif.ihit     = 1'b1;
            cif.imemload = rdata;
        end
        if (state == FILL) begin
            cif.iREN  = 1'b1;
            cif.iaddr = {miss_word, 2'b00};
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus random fetch
// traffic compared against a per-set word-address/data reference model.
module tb_icache_fetch;

    localparam int unsigned SETS = 16;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    icache_if cif();

    icache_fetch #(.SETS(SETS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .cif  (cif)
    );

    int checks = 0;
    int errors = 0;

    // Reference: which word address each set holds, and its data.
    bit          m_valid [SETS];
    logic [29:0] m_word  [SETS];
    logic [31:0] m_data  [SETS];

    function automatic int unsigned set_of(input logic [31:0] a);
        return (a >> 2) % SETS;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[set_of(a)] && (m_word[set_of(a)] == a[31:2]);
    endfunction

    task automatic m_clear();
        for (int unsigned i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    endtask

    // One complete fetch: lookup, and on a predicted miss a fill with 'waits'
    // busy cycles returning d, followed by the hit one cycle after completion.
    task automatic fetch(input logic [31:0] a, input int unsigned waits,
                         input logic [31:0] d, input bit drop);
        logic [31:0] wa;
        int unsigned s;
        bit exp_hit;
        wa = {a[31:2], 2'b00};
        s = set_of(a);
        exp_hit = m_hit(a);
        cif.imemREN = 1'b1; cif.imemaddr = a; cif.iwait = 1'b1;
        cif.iinvalidate = 1'b0; cif.iload = '0;
        #1;
        checks++;
        if (cif.ihit !== exp_hit) begin
            errors++; $display("FAIL fetch_lookup addr=%h ihit=%b expected=%b", a, cif.ihit, exp_hit);
        end
        if (exp_hit) begin
            checks++;
            if (cif.imemload !== m_data[s] || cif.iREN !== 1'b0) begin
                errors++; $display("FAIL fetch_hit_data addr=%h imemload=%h iREN=%b expected=%h/0", a, cif.imemload, cif.iREN, m_data[s]);
            end
        end else begin
            checks++;
            if (cif.imemload !== 32'h0 || cif.iREN !== 1'b0) begin
                errors++; $display("FAIL fetch_miss_idle addr=%h imemload=%h iREN=%b expected=0/0", a, cif.imemload, cif.iREN);
            end
            @(posedge CLK); #1;
            for (int unsigned k = 0; k <= waits; k++) begin
                cif.iwait = (k < waits);
                cif.iload = (k < waits) ? $urandom : d;
                if (drop) cif.imemREN = 1'b0;
                #1;
                checks++;
                if (cif.iREN !== 1'b1 || cif.iaddr !== wa || cif.ihit !== 1'b0 || cif.imemload !== 32'h0) begin
                    errors++; $display("FAIL fetch_fill addr=%h cyc=%0d iREN=%b iaddr=%h ihit=%b imemload=%h expected 1/%h/0/0", a, k, cif.iREN, cif.iaddr, cif.ihit, cif.imemload, wa);
                end
                @(posedge CLK); #1;
            end
            m_valid[s] = 1'b1; m_word[s] = a[31:2]; m_data[s] = d;
            cif.imemREN = 1'b1; cif.iwait = 1'b1;
            #1;
            checks++;
            if (cif.ihit !== 1'b1 || cif.imemload !== d || cif.iREN !== 1'b0) begin
                errors++; $display("FAIL fetch_after_fill addr=%h ihit=%b imemload=%h iREN=%b expected 1/%h/0", a, cif.ihit, cif.imemload, cif.iREN, d);
            end
        end
        cif.imemREN = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        cif.imemREN = 1'b1; cif.imemaddr = 32'h0; cif.iwait = 1'b1;
        cif.iinvalidate = 1'b0; cif.iload = '0;
        #2;
        checks++;
        if (cif.ihit !== 1'b0 || cif.imemload !== 32'h0 || cif.iREN !== 1'b0 || cif.iaddr !== 32'h0) begin
            errors++; $display("FAIL reset_outputs ihit=%b imemload=%h iREN=%b iaddr=%h expected all 0", cif.ihit, cif.imemload, cif.iREN, cif.iaddr);
        end
        cif.imemREN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        cif.imemREN = 1'b1;
        #1;
        checks++;
        if (cif.ihit !== 1'b0 || cif.imemload !== 32'h0) begin
            errors++; $display("FAIL reset_cold_miss ihit=%b imemload=%h expected 0/0", cif.ihit, cif.imemload);
        end
        cif.imemREN = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_first_fill();
        fetch(32'h0000_0000, 3, 32'h8C01_0004, 1'b0);
    endtask

    task automatic test_conflict();
        fetch(32'h0000_0004, 1, 32'h1111_1111, 1'b0);
        fetch(32'h0000_0044, 2, 32'h2222_2222, 1'b0);
        checks++;
        if (m_hit(32'h0000_0004) !== 1'b0) begin
            errors++; $display("FAIL conflict_model_evict hit=1 expected=0");
        end
        fetch(32'h0000_0004, 0, 32'h1111_1111, 1'b0);
    endtask

    task automatic test_redirect();
        logic [31:0] d10;
        d10 = 32'hA5A5_0010;
        cif.imemREN = 1'b1; cif.imemaddr = 32'h10; cif.iwait = 1'b1; cif.iinvalidate = 1'b0;
        #1;
        checks++;
        if (cif.ihit !== 1'b0) begin
            errors++; $display("FAIL redirect_miss ihit=%b expected=0", cif.ihit);
        end
        @(posedge CLK); #1;
        cif.imemaddr = 32'h100;
        for (int unsigned k = 0; k < 3; k++) begin
            cif.iwait = (k < 2);
            cif.iload = (k < 2) ? 32'hDEAD_BEEF : d10;
            #1;
            checks++;
            if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h10 || cif.ihit !== 1'b0) begin
                errors++; $display("FAIL redirect_hold cyc=%0d iREN=%b iaddr=%h ihit=%b expected 1/00000010/0", k, cif.iREN, cif.iaddr, cif.ihit);
            end
            @(posedge CLK); #1;
        end
        m_valid[4] = 1'b1; m_word[4] = 30'h4; m_data[4] = d10;
        cif.iwait = 1'b1;
        #1;
        checks++;
        if (cif.ihit !== m_hit(32'h100) || cif.iREN !== 1'b0) begin
            errors++; $display("FAIL redirect_new_lookup ihit=%b iREN=%b expected 0/0", cif.ihit, cif.iREN);
        end
        @(posedge CLK); #1;
        checks++;
        if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h100) begin
            errors++; $display("FAIL redirect_new_fill iREN=%b iaddr=%h expected 1/00000100", cif.iREN, cif.iaddr);
        end
        cif.iwait = 1'b0; cif.iload = 32'h0BAD_0100;
        @(posedge CLK); #1;
        m_valid[0] = 1'b1; m_word[0] = 30'h40; m_data[0] = 32'h0BAD_0100;
        cif.iwait = 1'b1; cif.imemaddr = 32'h10;
        #1;
        checks++;
        if (cif.ihit !== 1'b1 || cif.imemload !== d10) begin
            errors++; $display("FAIL redirect_set4_filled ihit=%b imemload=%h expected 1/%h", cif.ihit, cif.imemload, d10);
        end
        cif.imemREN = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int unsigned i = 0; i < SETS; i++)
            fetch(i * 4, $urandom_range(0, 2), $urandom, 1'b0);
        cif.imemREN = 1'b1;
        for (int unsigned i = 0; i < SETS; i++) begin
            a = (i * 4) | $urandom_range(0, 3);
            cif.imemaddr = a;
            #1;
            checks++;
            if (cif.ihit !== 1'b1 || cif.imemload !== m_data[i] || cif.iREN !== 1'b0) begin
                errors++; $display("FAIL back_to_back addr=%h ihit=%b imemload=%h iREN=%b expected 1/%h/0", a, cif.ihit, cif.imemload, cif.iREN, m_data[i]);
            end
            @(posedge CLK); #1;
        end
        cif.imemREN = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_invalidate();
        logic [31:0] prev [$];
        fetch(32'h48, 1, 32'h4848_4848, 1'b0);
        for (int unsigned i = 0; i < SETS; i++)
            if (m_valid[i]) prev.push_back({m_word[i], 2'b00});
        cif.imemREN = 1'b1; cif.imemaddr = 32'h08; cif.iwait = 1'b1;
        #1;
        @(posedge CLK); #1;
        cif.iwait = 1'b0; cif.iload = 32'h0808_0808; cif.iinvalidate = 1'b1;
        #1;
        checks++;
        if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h08) begin
            errors++; $display("FAIL inval_fill iREN=%b iaddr=%h expected 1/00000008", cif.iREN, cif.iaddr);
        end
        @(posedge CLK); #1;
        m_clear();
        cif.iinvalidate = 1'b0; cif.iwait = 1'b1;
        #1;
        checks++;
        if (cif.ihit !== 1'b0 || cif.iREN !== 1'b0) begin
            errors++; $display("FAIL inval_coincident ihit=%b iREN=%b expected 0/0", cif.ihit, cif.iREN);
        end
        cif.imemREN = 1'b0;
        @(posedge CLK); #1;
        foreach (prev[i]) begin
            cif.imemREN = 1'b1; cif.imemaddr = prev[i];
            #1;
            checks++;
            if (cif.ihit !== 1'b0) begin
                errors++; $display("FAIL inval_all_miss addr=%h ihit=%b expected=0", prev[i], cif.ihit);
            end
            cif.imemREN = 1'b0;
            @(posedge CLK); #1;
        end
        fetch(32'h20, 0, 32'h2020_2020, 1'b0);
        cif.imemREN = 1'b1; cif.imemaddr = 32'h20; cif.iinvalidate = 1'b1;
        #1;
        checks++;
        if (cif.ihit !== 1'b0 || cif.imemload !== 32'h0) begin
            errors++; $display("FAIL inval_forces_miss ihit=%b imemload=%h expected 0/0", cif.ihit, cif.imemload);
        end
        @(posedge CLK); #1;
        m_clear();
        checks++;
        if (cif.iREN !== 1'b0) begin
            errors++; $display("FAIL inval_no_new_miss iREN=%b expected=0", cif.iREN);
        end
        cif.iinvalidate = 1'b0;
        #1;
        checks++;
        if (cif.ihit !== 1'b0) begin
            errors++; $display("FAIL inval_cleared ihit=%b expected=0", cif.ihit);
        end
        cif.imemREN = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] probe [3];
        probe[0] = 32'h34; probe[1] = 32'h00; probe[2] = 32'h30;
        fetch(32'h34, 1, 32'h3434_3434, 1'b0);
        fetch(32'h00, 0, 32'h0000_1111, 1'b0);
        cif.imemREN = 1'b1; cif.imemaddr = 32'h30; cif.iwait = 1'b1;
        #1;
        @(posedge CLK); #1;
        checks++;
        if (cif.iREN !== 1'b1) begin
            errors++; $display("FAIL rst_fill_entered iREN=%b expected=1", cif.iREN);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (cif.iREN !== 1'b0 || cif.ihit !== 1'b0 || cif.imemload !== 32'h0 || cif.iaddr !== 32'h0) begin
            errors++; $display("FAIL rst_mid_fill iREN=%b ihit=%b imemload=%h iaddr=%h expected all 0", cif.iREN, cif.ihit, cif.imemload, cif.iaddr);
        end
        cif.imemREN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        m_clear();
        @(posedge CLK); #1;
        for (int unsigned i = 0; i < 3; i++) begin
            cif.imemREN = 1'b1; cif.imemaddr = probe[i];
            #1;
            checks++;
            if (cif.ihit !== 1'b0) begin
                errors++; $display("FAIL rst_post_miss addr=%h ihit=%b expected=0", probe[i], cif.ihit);
            end
            cif.imemREN = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int unsigned n = 0; n < 250; n++) begin
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = a | ($urandom & 32'hFFFF_0000);
            fetch(a, $urandom_range(0, 3), $urandom, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) begin
                cif.iinvalidate = 1'b1;
                @(posedge CLK); #1;
                cif.iinvalidate = 1'b0;
                m_clear();
            end
        end
    endtask

    initial begin
        nRST = 1'b0;
        cif.imemREN = 1'b0; cif.imemaddr = '0; cif.iinvalidate = 1'b0;
        cif.iwait = 1'b1; cif.iload = '0;
        m_clear();
        test_reset();
        test_first_fill();
        test_conflict();
        test_redirect();
        test_back_to_back();
        test_invalidate();
        test_reset_mid_fill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
